// File: rtl/l1_mem_responder.sv
// Memory-side responder for the L1 miss/writeback port: critical-word-first line refills
// and line-aligned writebacks against an internal word array, one transaction at a time.
module l1_mem_responder #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 1024,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_last,
  output logic              b_valid,
  input  logic              b_ready,
  output logic              busy
);

  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam int WIDX_W  = $clog2(MEM_WORDS);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int LINE_W  = WIDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, WACK} state_t;

  state_t             state;
  logic [DATA_W-1:0]  mem [MEM_WORDS];
  logic [LINE_W-1:0]  line_q;
  logic [OFF_W-1:0]   off_q;
  logic [OFF_W-1:0]   cnt;
  logic [OFF_W-1:0]   nxt_off;
  logic [WIDX_W-1:0]  widx;
  logic [WIDX_W-1:0]  rd_idx;
  logic [WIDX_W-1:0]  wr_idx;
  logic               req_hs;
  logic               addr_unused;

  // Bits above the array depth and below word granularity are deliberately dropped.
  assign widx        = req_addr[BYTE_SH +: WIDX_W];
  assign addr_unused = ^req_addr;

  assign req_ready = (state == IDLE);
  assign w_ready   = (state == WR);
  assign busy      = (state != IDLE);
  assign req_hs    = req_valid && (state == IDLE);

  // Offset wraps inside the line; never carries into the line index.
  assign nxt_off = off_q + cnt + OFF_W'(1);
  assign wr_idx  = {line_q, cnt};

  always_comb begin
    rd_idx = widx;
    if (state != IDLE) rd_idx = {line_q, nxt_off};
  end

  always_ff @(posedge clk) begin
    if (state == WR && w_valid) mem[wr_idx] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      line_q     <= '0;
      off_q      <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
      b_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_hs) begin
          line_q <= widx[WIDX_W-1:OFF_W];
          off_q  <= widx[OFF_W-1:0];
          cnt    <= '0;
          if (req_we) begin
            state <= WR;
          end else begin
            state      <= RD;
            resp_data  <= mem[rd_idx];
            resp_valid <= 1'b1;
            resp_last  <= 1'b0;
          end
        end
        RD: if (resp_ready) begin
          if (cnt == LAST_CNT) begin
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt       <= cnt + OFF_W'(1);
            resp_data <= mem[rd_idx];
            resp_last <= (cnt + OFF_W'(1) == LAST_CNT);
          end
        end
        WR: if (w_valid) begin
          cnt <= cnt + OFF_W'(1);
          if (cnt == LAST_CNT) begin
            b_valid <= 1'b1;
            state   <= WACK;
          end
        end
        WACK: if (b_ready) begin
          b_valid <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/l1_mem_responder.md
Name: l1_mem_responder

Overview:
- Memory-side responder for the L1 cache miss/writeback interface. The L1 cache initiates; this block answers.
- Serves one outstanding transaction at a time:
  - line refill: read burst, delivered critical-word-first;
  - line writeback: write burst.
- Backed by an internal word-addressed array with asynchronous read and synchronous write.
- Sits between the L1 cache and the on-chip memory. Also serves as the bench memory model for L1 verification.

Parameters:
- DATA_W, 32: beat/word width in bits; equals `XPR_LEN.
- LINE_WORDS, 4: words per cache line; power of two, at least 2.
- MEM_WORDS, 1024: backing array depth in words; power of two, multiple of LINE_WORDS.
- ADDR_W, 32: request byte-address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept; high only in IDLE.
- req_we  in  1  1 = writeback, 0 = refill.
- req_addr  in  ADDR_W  byte address of the requested word.
- w_valid  in  1  writeback beat valid.
- w_ready  out  1  writeback beat accept.
- w_data  in  DATA_W  writeback beat data.
- resp_valid  out  1  refill beat valid.
- resp_ready  in  1  refill beat accept.
- resp_data  out  DATA_W  refill beat data.
- resp_last  out  1  marks the final refill beat.
- b_valid  out  1  writeback complete.
- b_ready  in  1  writeback completion accept.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, state held while rst_n=0):
  - state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_last=0; w_ready=0; b_valid=0; busy=0.
  - No request is accepted while rst_n=0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst immediately. Words already written persist.
- Address decode:
  - widx = req_addr >> log2(DATA_W/8), taken modulo MEM_WORDS; higher bits are ignored (wrap-around).
  - off = widx mod LINE_WORDS.
  - base = widx with off cleared.
- Handshake rule (all channels): a transfer occurs in a cycle where valid and ready are both high.
- State machine: IDLE, RD, WR, WACK.
- IDLE:
  - req_ready=1.
  - On request handshake, latch base/off into registers and clear the beat counter cnt.
  - req_we=0 -> RD. In the same edge, load resp_data=mem[base+off] and set resp_valid=1. First beat is therefore visible the cycle after accept.
  - req_we=1 -> WR.
- RD:
  - Beat k carries mem[base + ((off+k) mod LINE_WORDS)]: critical word first, wrapping within the line.
  - resp_last=1 exactly when cnt=LINE_WORDS-1.
  - Holding rule: while resp_ready=0, resp_data, resp_last and resp_valid hold stable.
  - On a beat handshake with cnt<LINE_WORDS-1: cnt++ and the next beat loads on the same edge. Back-to-back beats need no bubble.
  - On the handshake of the last beat: resp_valid=0, resp_last=0 -> IDLE.
  - A full refill takes LINE_WORDS cycles minimum from the first resp_valid.
- WR:
  - w_ready=1.
  - Beats are always line-aligned: beat k writes mem[base+k]. The request offset is ignored.
  - Each w handshake writes the word on that edge and increments cnt. Gaps in w_valid are tolerated.
  - After the LINE_WORDS-th handshake: w_ready=0, b_valid=1 -> WACK.
- WACK:
  - b_valid holds until b_ready.
  - On the b handshake: b_valid=0 -> IDLE. req_ready is high the next cycle.
- Simultaneous and illegal events:
  - req_valid outside IDLE is ignored; req_ready=0.
  - w_valid outside WR is ignored.
  - resp_ready outside RD has no effect.
  - A write to the same word as a later read is visible to that read, since reads are asynchronous and transactions are serialized.
- cnt is log2(LINE_WORDS) bits. The offset sum wraps modulo LINE_WORDS with no carry into base.

Test Plan:
1. Preload mem[i]=0x1000+i for i=0..7; refill at req_addr=0x0 with resp_ready=1 -> resp_valid one cycle after accept. Beats 0x1000, 0x1001, 0x1002, 0x1003 on four consecutive cycles; resp_last on the 4th; req_ready=1 the cycle after.
2. Refill at req_addr=0x18 (word 6) -> beats 0x1006, 0x1007, 0x1004, 0x1005; resp_last on 0x1005.
3. Refill at 0x0 with resp_ready=0 for 3 cycles while beat 2 is presented -> resp_data stays 0x1001, resp_valid stays 1. Resumes with 0x1002 the cycle after resp_ready rises.
4. Writeback at req_addr=0x14 with w_data 0xA0..0xA3 and one idle cycle between beats 1 and 2 -> mem[4..7]=0xA0..0xA3. b_valid rises the cycle after the 4th beat and holds 5 cycles with b_ready=0. A following refill at 0x10 returns 0xA0..0xA3.
5. Assert rst_n=0 after the 2nd refill beat -> all outputs drop immediately to reset values. After release, req_ready=1 and a refill at 0x0 returns 0x1000..0x1003.
6. With MEM_WORDS=1024, refill at req_addr=0x1008 -> wraps to word 2. Beats 0x1002, 0x1003, 0x1000, 0x1001.
